alu_ctrl_issue: RTL

//  Registered ALU-control decoder. Converts the main-decoder ALUOp and R-type funct into the 3-bit ALU control code.

---
 rtl/alu_ctrl_issue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_ctrl_issue.sv
// Registered ALU-control decoder feeding a DEPTH-entry skid buffer with valid/ready on both sides.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (stores the unsupported-funct flag and drives illegal).
module alu_ctrl_issue #(
  parameter int DEPTH  = 2,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam int ENTRY_W = CTRL_W + 1;
`else
  localparam int ENTRY_W = CTRL_W;
`endif

  function automatic logic [CTRL_W-1:0] dec_code(input logic [1:0] op, input logic [5:0] fn);
    logic [CTRL_W-1:0] c;
    case (op)
      2'b00:   c = 3'b010;
      2'b01:   c = 3'b110;
      2'b11:   c = 3'b001;
      default: begin
        case (fn)
          6'b100000: c = 3'b010;
          6'b100010: c = 3'b110;
          6'b100100: c = 3'b000;
          6'b100101: c = 3'b001;
          6'b101010: c = 3'b111;
          default:   c = 3'b010;
        endcase
      end
    endcase
    return c;
  endfunction

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  function automatic logic dec_unsup(input logic [1:0] op, input logic [5:0] fn);
    logic u;
    u = 1'b0;
    if (op == 2'b10) begin
      case (fn)
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: u = 1'b0;
        default: u = 1'b1;
      endcase
    end
    return u;
  endfunction
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] wr_entry;
  logic               push, pop;

  // Ready depends only on registered occupancy, so a pop never frees a same-cycle push slot.
  assign in_ready  = !reset && (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign wr_entry    = {dec_unsup(alu_op, funct), dec_code(alu_op, funct)};
  assign illegal     = out_valid && mem_q[rd_ptr_q][CTRL_W];
`else
  assign wr_entry    = dec_code(alu_op, funct);
  assign illegal     = 1'b0;
`endif
  assign alu_control = mem_q[rd_ptr_q][CTRL_W-1:0];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer storage is cleared on reset so the head reads 000 until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_seen;

  always_ff @(posedge clk) begin
    if (reset)                                   illegal_seen <= 1'b0;
    else if (push && wr_entry[CTRL_W])           illegal_seen <= 1'b1;
  end
`endif

endmodule
